// File: rtl/ram32_master_if.sv
// Client-side handshake and RAM control signals of ram32_master.
// The bidirectional RAM data bus stays a plain inout port on the master.
interface ram32_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              wd_ready;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wre;

    modport master (
        input  req, req_we, req_addr, req_len, req_wdata,
        output wd_ready, busy, rd_data, rd_valid, done, mem_addr, mem_wre
    );

    modport slave (
        output req, req_we, req_addr, req_len, req_wdata,
        input  wd_ready, busy, rd_data, rd_valid, done, mem_addr, mem_wre
    );
endinterface

// File: rtl/ram32_master.sv
// Burst master for a single-port RAM with a shared tri-state data bus.
// Bursts of 1..8 words; a one-cycle DONE state provides bus turnaround.
module ram32_master #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    ram32_master_if.master      bus,
    inout  wire  [DATA_W-1:0]   mem_data
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              write_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = bus.req_len;
                    state_d = bus.req_we ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                // Address holds on the last beat so IDLE keeps the final beat address.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == READ) begin
            rd_data_d  = mem_data;
            rd_valid_d = 1'b1;
        end
    end

    assign write_beat   = (state_q == WRITE);

    assign bus.mem_wre  = write_beat;
    assign bus.wd_ready = write_beat;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.mem_addr = addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    assign mem_data = write_beat ? bus.req_wdata : {DATA_W{1'bz}};
endmodule
